// File: rtl/nios2_oci_pkg.sv
// rtl/nios2_oci_pkg.sv - shared FSM/grant types and jdo field positions for the OCI RAM arbiter
package nios2_oci_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
  typedef enum logic {GNT_CPU, GNT_JTAG} grant_t;

  localparam int JDO_W       = 38;
  localparam int ADDR_LSB    = 2;
  localparam int WDATA_LSB   = 3;
  localparam int RD_BIT      = 34;
  localparam int CLR_ERR_BIT = 35;

endpackage

// File: rtl/nios2_oci_jtag_cmd.sv
// rtl/nios2_oci_jtag_cmd.sv - decodes JTAG ocimem strobes into a single pending command,
// owns MonAReg with auto-increment and the sticky overrun flag.
module nios2_oci_jtag_cmd
  import nios2_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              jtag_done,
  output logic              jtag_pend,
  output logic              jtag_is_write,
  output logic [DATA_W-1:0] jtag_wdata,
  output logic              cmd_accept,
  output logic [ADDR_W-1:0] mon_areg,
  output logic              monitor_error
);

  logic              pend_q, pend_d;
  logic              is_write_q, is_write_d;
  logic              noinc_q, noinc_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] areg_q, areg_d;
  logic              queue_req;
  logic              overrun;
  logic              set_addr;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:CLR_ERR_BIT+1], jdo[ADDR_LSB-1:0]};

  always_comb begin
    queue_req  = take_action_ocimem_b | take_no_action_ocimem_a |
                 (take_action_ocimem_a & jdo[RD_BIT]);
    // A completing command frees the slot in the same cycle a new one arrives.
    cmd_accept = queue_req & (~pend_q | jtag_done);
    overrun    = queue_req & ~cmd_accept;
    set_addr   = take_action_ocimem_a & (~jdo[RD_BIT] | cmd_accept);

    pend_d     = pend_q;
    is_write_d = is_write_q;
    noinc_d    = noinc_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    areg_d     = areg_q;

    if (jtag_done) begin
      pend_d = 1'b0;
      if (!noinc_q) begin
        areg_d = areg_q + 1'b1;
      end
    end
    if (cmd_accept) begin
      pend_d     = 1'b1;
      is_write_d = take_action_ocimem_b;
      noinc_d    = take_action_ocimem_a;
      if (take_action_ocimem_b) begin
        wdata_d = jdo[WDATA_LSB +: DATA_W];
      end
    end
    if (set_addr) begin
      areg_d = jdo[ADDR_LSB +: ADDR_W];
      if (jdo[CLR_ERR_BIT]) begin
        err_d = 1'b0;
      end
    end
    if (overrun) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      is_write_q <= 1'b0;
      noinc_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      areg_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      is_write_q <= is_write_d;
      noinc_q    <= noinc_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      areg_q     <= areg_d;
    end
  end

  assign jtag_pend     = pend_q;
  assign jtag_is_write = is_write_q;
  assign jtag_wdata    = wdata_q;
  assign mon_areg      = areg_q;
  assign monitor_error = err_q;

endmodule

// File: rtl/nios2_oci_mem_arbiter.sv
// rtl/nios2_oci_mem_arbiter.sv - round-robin sharing of the OCI debug RAM between CPU and JTAG.
// OCIMEM_WRPROT_EN: discard CPU writes at or above PROT_BASE and pulse cpu_err.
module nios2_oci_mem_arbiter
  import nios2_oci_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 32,
  parameter int              RAM_LAT   = 1,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hE0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_waitrequest,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // Counter starts one below RAM_LAT because the ACCESS cycle is the first latency cycle.
  localparam logic [1:0] CNT_INIT = 2'(RAM_LAT - 1);

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  grant_t            gnt;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              mon_ready_q, mon_ready_d;

  logic              cpu_req;
  logic              done;
  logic              cpu_done;
  logic              jtag_done;
  logic              prot_hit;
  logic              jtag_pend;
  logic              jtag_is_write;
  logic [DATA_W-1:0] jtag_wdata;
  logic              cmd_accept;

  nios2_oci_jtag_cmd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_cmd (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jtag_done               (jtag_done),
    .jtag_pend               (jtag_pend),
    .jtag_is_write           (jtag_is_write),
    .jtag_wdata              (jtag_wdata),
    .cmd_accept              (cmd_accept),
    .mon_areg                (MonAReg),
    .monitor_error           (monitor_error)
  );

  assign cpu_req   = cpu_read | cpu_write;
  assign done      = ((state_q == ACCESS) && is_write_q) || ((state_q == RDWAIT) && (cnt_q == 2'd0));
  assign cpu_done  = done && (last_grant_q == GNT_CPU);
  assign jtag_done = done && (last_grant_q == GNT_JTAG);

`ifdef OCIMEM_WRPROT_EN
  assign prot_hit = (state_q == ACCESS) && is_write_q && (last_grant_q == GNT_CPU) &&
                    (addr_q >= PROT_BASE);
`else
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
  assign prot_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt          = GNT_JTAG;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || jtag_pend) begin
          if (cpu_req && jtag_pend) begin
            gnt = (last_grant_q == GNT_JTAG) ? GNT_CPU : GNT_JTAG;
          end else begin
            gnt = cpu_req ? GNT_CPU : GNT_JTAG;
          end
          last_grant_d = gnt;
          if (gnt == GNT_CPU) begin
            is_write_d = cpu_write;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
          end else begin
            is_write_d = jtag_is_write;
            addr_d     = MonAReg;
            wdata_d    = jtag_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (is_write_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = CNT_INIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    mon_dreg_d  = mon_dreg_q;
    mon_ready_d = mon_ready_q;
    if (cpu_done && !is_write_q) begin
      cpu_rdata_d = ram_rdata;
    end
    if (jtag_done) begin
      mon_ready_d = 1'b1;
      if (!is_write_q) begin
        mon_dreg_d = ram_rdata;
      end
    end
    // A newly queued command supersedes the ready of one completing alongside it.
    if (cmd_accept) begin
      mon_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_JTAG;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 2'd0;
      cpu_rdata_q  <= '0;
      mon_dreg_q   <= '0;
      mon_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mon_dreg_q   <= mon_dreg_d;
      mon_ready_q  <= mon_ready_d;
    end
  end

  assign ram_addr        = addr_q;
  assign ram_wdata       = wdata_q;
  assign ram_re          = (state_q == ACCESS) && !is_write_q;
  assign ram_we          = (state_q == ACCESS) && is_write_q && !prot_hit;
  assign cpu_err         = prot_hit;
  assign cpu_waitrequest = !cpu_done;
  assign cpu_rdata       = (cpu_done && !is_write_q) ? ram_rdata : cpu_rdata_q;
  assign MonDReg         = mon_dreg_q;
  assign monitor_ready   = mon_ready_q;

endmodule
